// File: rtl/alu_pkg.sv
// Shared ALU control encoding and sequencer state type, common to the
// single-cycle and bit-serial execute paths.
package alu_pkg;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_OR     = 3'b101;
    localparam logic [2:0] ALU_XOR    = 3'b110;

    typedef enum logic [1:0] {IDLE, RUN, DONE} salu_state_t;

    // Only add/sub produce meaningful carry and overflow flags.
    function automatic logic isArith(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// One-bit ALU slice; drop-in compatible with the single-cycle ALU bit cell.
module serial_alu_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       y,
    output logic       cout
);

    logic bx;

    // Subtract is A + ~B + 1; the +1 arrives as the initial carry.
    assign bx = b ^ (op == ALU_SUB);

    always_comb begin
        y    = 1'b0;
        cout = 1'b0;
        case (op)
            ALU_PASS_B: y = b;
            ALU_ADD, ALU_SUB: begin
                y    = a ^ bx ^ cin;
                cout = (a & bx) | (a & cin) | (bx & cin);
            end
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            default: ;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU sequencer: one slice driven LSB-first for WIDTH cycles,
// then results and NZVC flags are published with a one-cycle done pulse.
module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);

    salu_state_t      state, nextState;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] aSh, bSh, resSh;
    logic [2:0]       opQ;
    logic             carryQ, cMsbIn, cMsbOut;
    logic             sliceY, sliceCout;
    logic             lastBit, accept;

    serial_alu_slice uSlice (
        .a    (aSh[0]),
        .b    (bSh[0]),
        .cin  (carryQ),
        .op   (opQ),
        .y    (sliceY),
        .cout (sliceCout)
    );

    // The done cycle is spent in IDLE, so hold off ready until it has passed.
    assign ready   = (state == IDLE) && !done;
    assign accept  = start && ready;
    assign lastBit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept)  nextState = RUN;
            RUN:     if (lastBit) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            aSh       <= '0;
            bSh       <= '0;
            resSh     <= '0;
            opQ       <= '0;
            carryQ    <= 1'b0;
            cMsbIn    <= 1'b0;
            cMsbOut   <= 1'b0;
            result    <= '0;
            done      <= 1'b0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    aSh    <= A;
                    bSh    <= B;
                    opQ    <= cntrl;
                    cnt    <= '0;
                    carryQ <= (cntrl == ALU_SUB);
                end
                RUN: begin
                    resSh  <= {sliceY, resSh[WIDTH-1:1]};
                    aSh    <= aSh >> 1;
                    bSh    <= bSh >> 1;
                    carryQ <= sliceCout;
                    cnt    <= cnt + 1'b1;
                    if (lastBit) begin
                        cMsbIn  <= carryQ;
                        cMsbOut <= sliceCout;
                    end
                end
                DONE: begin
                    result    <= resSh;
                    negative  <= resSh[WIDTH-1];
                    zero      <= ~|resSh;
                    carry_out <= isArith(opQ) & cMsbOut;
                    overflow  <= isArith(opQ) & (cMsbIn ^ cMsbOut);
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu with a transaction-level reference model.
module tb_serial_alu;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset, start, ready, done;
    logic [W-1:0] A, B, result;
    logic [2:0]   cntrl;
    logic         negative, zero, overflow, carry_out;

    int nVec = 0;
    int nErr = 0;

    typedef struct packed {
        logic [W-1:0] r;
        logic n, z, v, c;
    } exp_t;

    serial_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready),
        .A(A), .B(B), .cntrl(cntrl), .result(result), .done(done),
        .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t compute(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        exp_t     e;
        logic [W:0] s;
        e = '0;
        s = '0;
        case (op)
            3'b000: e.r = b;
            3'b010: begin
                s   = {1'b0, a} + {1'b0, b};
                e.r = s[W-1:0];
                e.c = s[W];
                e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            3'b011: begin
                s   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
                e.r = s[W-1:0];
                e.c = s[W];
                e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            3'b100: e.r = a & b;
            3'b101: e.r = a | b;
            3'b110: e.r = a ^ b;
            default: e.r = '0;
        endcase
        e.n = e.r[W-1];
        e.z = (e.r == '0);
        return e;
    endfunction

    // Reference model: an accepted op becomes visible W+1 edges later.
    int   mCnt = 0;
    logic mDone = 1'b0;
    bit   mInit = 0;
    exp_t mOut = '0, mPend = '0;

    always @(posedge clk) begin
        if (!reset) begin
            mCnt  = 0;
            mDone = 1'b0;
            mOut  = '0;
            mInit = 1;
        end else if (mInit) begin
            if (mCnt == 0 && !mDone && start) begin
                mPend = compute(A, B, cntrl);
                mCnt  = W + 1;
                mDone = 1'b0;
            end else if (mCnt != 0) begin
                mCnt--;
                mDone = (mCnt == 0);
                if (mCnt == 0) mOut = mPend;
            end else begin
                mDone = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mInit) begin
            check("ready", ready, (mCnt == 0 && !mDone));
            check("done", done, mDone);
            check("result", result, mOut.r);
            check("negative", negative, mOut.n);
            check("zero", zero, mOut.z);
            check("overflow", overflow, mOut.v);
            check("carry_out", carry_out, mOut.c);
        end
    end

    task automatic waitReady();
        int n = 0;
        while (!ready && n < 200) begin @(negedge clk); n++; end
        check("wait_ready", ready, 1);
    endtask

    task automatic waitDone(input string nm);
        int n = 0;
        while (!done && n < W + 10) begin @(negedge clk); n++; end
        check(nm, done, 1);
    endtask

    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         input logic [W-1:0] er, input logic en, input logic ez,
                         input logic ev, input logic ec);
        int low = 0;
        int pulses = 0;
        waitReady();
        A = a; B = b; cntrl = op; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!ready && low < W + 10) begin
            if (done) begin
                pulses++;
                check("lit_result", result, er);
                check("lit_n", negative, en);
                check("lit_z", zero, ez);
                check("lit_v", overflow, ev);
                check("lit_c", carry_out, ec);
            end
            low++;
            @(negedge clk);
        end
        check("ready_low_cycles", low, W + 2);
        check("done_pulses", pulses, 1);
        check("result_hold", result, er);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; A = '0; B = '0; cntrl = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_result", result, 0);
        reset = 1'b1;

        runOp(64'd5, 64'd7, 3'b010, 64'd12, 0, 0, 0, 0);
        runOp(64'h1234, 64'h1234, 3'b011, 64'd0, 0, 1, 0, 1);
        runOp(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'h8000_0000_0000_0000, 1, 0, 1, 0);
        runOp(64'hF0F0, 64'hFF00, 3'b100, 64'hF000, 0, 0, 0, 0);
        runOp(64'hF0F0, 64'hFF00, 3'b101, 64'hFFF0, 0, 0, 0, 0);
        runOp(64'hF0F0, 64'hFF00, 3'b110, 64'h0FF0, 0, 0, 0, 0);
        runOp(64'hF0F0, 64'hFF00, 3'b000, 64'hFF00, 0, 0, 0, 0);
        runOp(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'd0, 0, 1, 0, 1);
        runOp(64'd3, 64'd5, 3'b011, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 0);
        runOp(64'hFFFF, 64'hFFFF, 3'b111, 64'd0, 0, 1, 0, 0);

        // Handshake: starts in RUN and in the done cycle are ignored
        waitReady();
        A = 64'd3; B = 64'd4; cntrl = 3'b010; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = 64'd9; B = 64'd9; cntrl = 3'b011;
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("hs_done");
        check("hs_result", result, 64'd7);
        A = 64'd10; B = 64'd20; cntrl = 3'b010; start = 1'b1;
        @(negedge clk);
        check("hs_ready_after_done", ready, 1);
        check("hs_result_hold", result, 64'd7);
        @(negedge clk);
        start = 1'b0;
        check("hs_accepted", ready, 0);
        waitDone("hs_done2");
        check("hs_result2", result, 64'd30);

        // Reset in the middle of RUN aborts the op
        waitReady();
        @(negedge clk);
        A = 64'd100; B = 64'd200; cntrl = 3'b010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_result", result, 0);
        check("abort_zero", zero, 0);
        check("abort_carry", carry_out, 0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready", ready, 1);
        begin
            int pulses = 0;
            for (int i = 0; i < W + 5; i++) begin
                if (done) pulses++;
                @(negedge clk);
            end
            check("abort_no_done", pulses, 0);
        end
        runOp(64'd1, 64'd1, 3'b010, 64'd2, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule
